uart_tx_stim: RTL and testbench

- Simulation-and-synthesisable UART transmitter that drives serial bytes into the platform's UART receive pin: host/bench pushes bytes via valid/ready, block frames them 8N1 and shifts them out LSB-first.
- Counterpart of the uart_capture receiver on the output pin; sits beside Platform on the same 50 MHz system clock.
- Contains a small byte FIFO so a bench can queue a command string without per-byte waits.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_stim_if.sv | 15 +
 rtl/uart_tx_fifo.sv | 68 ++++++
 rtl/uart_tx_stim.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_stim.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit stimulus block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DEFAULT_CLK_DIV = 434;
    localparam int   DATA_BITS       = 8;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_stim_if.sv
// Purpose: byte handshake bundle feeding the UART transmitter FIFO.
// Latency: n/a (wires only).
// Backpressure: in_ready low holds the producer; a byte moves when in_valid & in_ready.
// Signals: in_valid (byte offered), in_data (byte), in_ready (FIFO has room).
interface uart_tx_stim_if;
    import uart_pkg::*;

    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous FIFO with push/pop, full/empty flags and occupancy count.
// Latency: pushed word readable at pop_data the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clock, reset_n (async active-low), push/push_data, pop/pop_data (head), full, empty, count.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Depth is a power of two, so pointers wrap naturally at AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_stim.sv
// Purpose: UART transmitter, queues bytes in a FIFO and shifts them out 8N1 (8E1 with UART_TX_PARITY_EN), LSB first.
// Latency: byte accepted into an empty FIFO at edge E is popped at E+1 and txd goes low from E+1.
// Backpressure: in_ready = !full from registered state only; queued frames go back-to-back with no idle gap.
// Ports: clock, reset_n (async active-low), in_if (slave: in_valid/in_data/in_ready),
//        txd (idle high), busy, tx_done (last cycle of stop bit), fifo_count.
module uart_tx_stim
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    uart_tx_stim_if.slave                 in_if,
    output logic                          txd,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    if (CLK_DIV < 2 || CLK_DIV > 65535 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $fatal(1, "uart_tx_stim: CLK_DIV must be 2..65535 and FIFO_DEPTH a power of two >= 2");
    end

    localparam logic [15:0] CNT_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  IDX_LAST   = 3'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 rdy_en_q, rdy_en_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic                 fifo_pop, fifo_full, fifo_empty, bit_end;
    logic [DATA_BITS-1:0] fifo_head;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (in_if.in_valid & in_if.in_ready),
        .push_data (in_if.in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // rdy_en_q keeps in_ready low throughout reset and releases it one edge later.
    assign in_if.in_ready = rdy_en_q & ~fifo_full;
    assign busy           = (state_q != IDLE) | (fifo_count != '0);
    assign txd            = txd_q;
    assign bit_end        = (cnt_q == 16'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        rdy_en_d = 1'b1;
        fifo_pop = 1'b0;
        tx_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != IDLE && !bit_end) cnt_d = cnt_q - 16'd1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                    cnt_d    = CNT_RELOAD;
                    shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
                    par_d    = even_parity(fifo_head);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    cnt_d   = CNT_RELOAD;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_RELOAD;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = CNT_RELOAD;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    // Chain straight into the next frame when one is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                        cnt_d    = CNT_RELOAD;
                        shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
                        par_d    = even_parity(fifo_head);
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so txd changes cleanly on the edge.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= '0;
            txd_q    <= UART_IDLE_LEVEL;
            rdy_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            rdy_en_q <= rdy_en_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Purpose: self-checking bench for uart_tx_stim with a line-level UART decoder and byte scoreboard.
// Latency: n/a.
// Backpressure: stimulus honours in_ready; the decoder is passive.
module tb_uart_tx_stim;

    localparam int DIV   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       txd, busy, tx_done;
    logic [3:0] fifo_count;

    uart_tx_stim_if in_if ();

    uart_tx_stim #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_if      (in_if),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc++;

    logic [7:0] exp_q[$];
    logic [7:0] tx_list[$];
    int  rst_gen        = 0;
    int  frames_started = 0;
    int  frames_ok      = 0;
    int  done_cnt       = 0;
    int  last_start     = -1;
    int  last_done      = -1;
    int  first_acc      = -1;
    int  stall_acc      = -1;
    bit  mon_in_frame   = 1'b0;

    always @(negedge clock) if (tx_done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer every byte of tx_list with in_valid held; bytes enter the scoreboard as accepted.
    task automatic send_list(input int budget, input string name);
        int t = 0;
        int n = 0;
        stall_acc = -1;
        first_acc = -1;
        @(negedge clock);
        while (tx_list.size() > 0 && t < budget) begin
            in_if.in_valid = 1'b1;
            in_if.in_data  = tx_list[0];
            if (in_if.in_ready === 1'b1) begin
                exp_q.push_back(tx_list.pop_front());
                n++;
                if (first_acc < 0) first_acc = cyc + 1;
            end else if (stall_acc < 0) begin
                stall_acc = n;
            end
            @(negedge clock);
            t++;
        end
        in_if.in_valid = 1'b0;
        check({name, "_send_in_time"}, (t < budget), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        @(negedge clock);
        while ((busy !== 1'b0 || mon_in_frame) && t < budget) begin
            @(negedge clock);
            t++;
        end
        check({name, "_idle_in_time"}, (t < budget), 1);
    endtask

    // Line decoder: finds a start bit, samples each bit at its centre, and scores the byte.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && txd === 1'b0) begin : frame
                int s;
                int g;
                logic [7:0] b;
                logic st, sp, p;
                s = cyc;
                g = rst_gen;
                mon_in_frame = 1'b1;
                frames_started++;
                last_start = s;
                b = 8'h00;
                p = 1'b0;
                repeat (DIV / 2) @(negedge clock);
                st = txd;
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge clock);
                    b[k] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clock);
                p = txd;
`endif
                repeat (DIV) @(negedge clock);
                sp = txd;
                repeat (DIV / 2 - 1) @(negedge clock);
                if (g == rst_gen) begin
                    check("start_bit", st, 1'b0);
                    check("stop_bit", sp, 1'b1);
                    check("tx_done_last_stop_cycle", tx_done, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected no frame", b);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("frame_byte", b, e);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", p, ^e);
`endif
                    end
                    frames_ok++;
                    last_done = cyc;
                end
                mon_in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e, fs, t;
        in_if.in_valid = 1'b0;
        in_if.in_data  = 8'h00;

        // Reset state
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_txd", txd, 1'b1);
        check("rst_in_ready", in_if.in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("in_ready_after_release", in_if.in_ready, 1'b1);

        // Single byte 0x55: start one edge after accept, tx_done on the last frame cycle
        tx_list.push_back(8'h55);
        send_list(20, "t1");
        e = first_acc;
        while (cyc < e + FRAME) @(negedge clock);
        check("t1_busy_in_stop", busy, 1'b1);
        check("t1_tx_done_cycle", tx_done, 1'b1);
        @(negedge clock);
        check("t1_busy_dropped", busy, 1'b0);
        check("t1_tx_done_one_cycle", tx_done, 1'b0);
        check("t1_start_cycle", last_start, e + 1);
        check("t1_done_cycle", last_done, e + FRAME);

        // Ten bytes with in_valid held: 9 accepts before stall, frames back-to-back
        wait_idle(200, "t2_pre");
        fs = frames_ok;
        for (int i = 0; i < 10; i++) tx_list.push_back(8'(i));
        send_list(300, "t2");
        e = first_acc;
        check("t2_accepts_before_stall", stall_acc, 9);
        wait_idle(20 * FRAME, "t2");
        check("t2_frames", frames_ok - fs, 10);
        check("t2_total_cycles", last_done - e, 10 * FRAME);

        // Simultaneous push and pop with three queued
        tx_list.push_back(8'hA1);
        tx_list.push_back(8'hA2);
        tx_list.push_back(8'hA3);
        tx_list.push_back(8'hA4);
        send_list(20, "t3");
        t = 0;
        while (tx_done !== 1'b1 && t < 2 * FRAME) begin
            @(negedge clock);
            t++;
        end
        check("t3_found_tx_done", (t < 2 * FRAME), 1);
        check("t3_count_before", fifo_count, 3);
        check("t3_ready_before", in_if.in_ready, 1'b1);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'hB5;
        exp_q.push_back(8'hB5);
        @(negedge clock);
        in_if.in_valid = 1'b0;
        check("t3_count_after_push_pop", fifo_count, 3);
        wait_idle(10 * FRAME, "t3");

        // Reset in the middle of the 0xFF data bits with two bytes queued
        tx_list.push_back(8'hFF);
        tx_list.push_back(8'h11);
        tx_list.push_back(8'h22);
        send_list(20, "t4");
        e = first_acc;
        while (cyc < e + 1 + 4 * DIV) @(negedge clock);
        check("t4_mid_data_count", fifo_count, 2);
        #2;
        rst_gen++;
        reset_n = 1'b0;
        #1;
        check("t4_txd_async", txd, 1'b1);
        check("t4_count_flushed", fifo_count, 0);
        check("t4_busy_cleared", busy, 1'b0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        fs = frames_started;
        repeat (3 * FRAME) @(negedge clock);
        check("t4_no_frames_after_reset", frames_started, fs);
        check("t4_txd_idle", txd, 1'b1);
        check("t4_busy_idle", busy, 1'b0);

        // Random bytes with random gaps, plus the parity corner bytes
        tx_list.push_back(8'h07);
        send_list(20, "t5a");
        tx_list.push_back(8'h03);
        send_list(20, "t5b");
        for (int i = 0; i < 24; i++) begin
            tx_list.push_back(8'($urandom));
            send_list(FRAME * (DEPTH + 2), "t5");
            repeat ($urandom_range(0, 30)) @(negedge clock);
        end
        wait_idle(40 * FRAME, "t5");

        check("scoreboard_drained", exp_q.size(), 0);
        check("tx_done_per_frame", done_cnt, frames_ok);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
